// File: rtl/elastic_stage_chain.sv
// rtl/elastic_stage_chain.sv - parametrised chain of valid/ready processing stages with flush and status
module elastic_stage_chain #(
    parameter int DATA_W    = 8,
    parameter int STAGES    = 3,
    parameter int STAGE_LAT = 2,
    parameter int MODE      = 0,
    localparam int OCC_W    = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy,
    output logic [15:0]       done_count,
    output logic              busy
);

    localparam int CNT_W = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WORK  = 2'd1,
        HOLD  = 2'd2
    } stage_state_t;

    stage_state_t      st     [STAGES];
    stage_state_t      st_n   [STAGES];
    logic [CNT_W-1:0]  cnt    [STAGES];
    logic [CNT_W-1:0]  cnt_n  [STAGES];
    logic [DATA_W-1:0] dat    [STAGES];
    logic [DATA_W-1:0] dat_n  [STAGES];
    logic [DATA_W-1:0] up_data[STAGES];
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] ready_v;
    logic [STAGES:0]   take;
    logic [OCC_W-1:0]  occ_n;

    assign out_valid = (st[STAGES-1] == HOLD);
    assign out_data  = dat[STAGES-1];
    assign in_ready  = !rst && !flush && ready_v[0];

    always_comb begin
        take     = '0;
        ready_v  = '0;
        up_valid = '0;
        occ_n    = '0;
        for (int k = 0; k < STAGES; k++) begin
            st_n[k]    = st[k];
            cnt_n[k]   = cnt[k];
            dat_n[k]   = dat[k];
            up_data[k] = '0;
        end

        up_valid[0] = in_valid && !flush && !rst;
        up_data[0]  = in_data;
        for (int k = 1; k < STAGES; k++) begin
            up_valid[k] = (st[k-1] == HOLD);
            up_data[k]  = dat[k-1];
        end

        // Ready ripples from the consumer back to the producer so a full
        // chain can shift every item forward in a single cycle.
        take[STAGES] = out_valid && out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready_v[k] = (st[k] == EMPTY) || ((st[k] == HOLD) && take[k+1]);
            take[k]    = up_valid[k] && ready_v[k];
        end

        for (int k = 0; k < STAGES; k++) begin
            case (st[k])
                WORK: begin
                    if (cnt[k] == '0) st_n[k] = HOLD;
                    else              cnt_n[k] = cnt[k] - CNT_W'(1);
                end
                HOLD: begin
                    if (take[k+1]) st_n[k] = EMPTY;
                end
                default: ;
            endcase
            if (take[k]) begin
                st_n[k]  = WORK;
                cnt_n[k] = CNT_W'(STAGE_LAT - 1);
                dat_n[k] = (MODE == 1) ? up_data[k] + DATA_W'(1) : up_data[k];
            end
            // Flush empties the stages but leaves counters and data untouched.
            if (flush) begin
                st_n[k]  = EMPTY;
                cnt_n[k] = cnt[k];
                dat_n[k] = dat[k];
            end
            if (st_n[k] != EMPTY) occ_n = occ_n + OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st[k]  <= EMPTY;
                cnt[k] <= '0;
                dat[k] <= '0;
            end
            occupancy  <= '0;
            busy       <= 1'b0;
            done_count <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                st[k]  <= st_n[k];
                cnt[k] <= cnt_n[k];
                dat[k] <= dat_n[k];
            end
            occupancy <= occ_n;
            busy      <= (occ_n != '0);
            if (take[STAGES] && !flush) done_count <= done_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_elastic_stage_chain.sv
// tb/tb_elastic_stage_chain.sv - directed scoreboard bench for elastic_stage_chain
module tb_elastic_stage_chain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, busy;
    logic [7:0]  out_data;
    logic [1:0]  occupancy;
    logic [15:0] done_count;

    logic        in_ready1, out_valid1, busy1;
    logic [7:0]  out_data1;
    logic [1:0]  occupancy1;
    logic [15:0] done_count1;

    elastic_stage_chain #(.DATA_W(8), .STAGES(3), .STAGE_LAT(2), .MODE(0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .done_count(done_count), .busy(busy)
    );

    elastic_stage_chain #(.DATA_W(8), .STAGES(3), .STAGE_LAT(2), .MODE(1)) dut_inc (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occupancy1), .done_count(done_count1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         tests = 0;
    int         fails = 0;
    int         exp_done = 0;
    int         acc_edge = 0;
    logic [7:0] exp_q[$];
    int         del_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every handshake at the output pops the oldest accepted item.
    always @(negedge clk) begin
        logic [7:0] e;
        #2;
        if (!rst) begin
            check("done_count_track", {16'h0, done_count}, 32'(exp_done));
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL spurious_output: observed %0h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {24'h0, out_data}, {24'h0, e});
                    check("out_data_mode1", {24'h0, out_data1}, {24'h0, 8'(e + 8'd3)});
                    del_q.push_back(cyc + 1);
                    exp_done++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input int budget, output int waited);
        waited   = -1;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back(d);
                @(posedge clk);
                @(negedge clk);
                acc_edge = cyc;
                waited   = i;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("accepted", 32'(waited >= 0), 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_latency(input string tag);
        int a;
        a = acc_edge;
        while (cyc < a + 7) @(negedge clk);
        check({tag, "_early"}, {31'h0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w, prev;

        #3;
        check("rst_in_ready", {31'h0, in_ready}, 32'd0);
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_occupancy", {30'h0, occupancy}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_out_data", {24'h0, out_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'h0, in_ready}, 32'd1);
        @(negedge clk);

        // Single item, full latency
        send(8'h05, 10, w);
        check_latency("single");
        check("single_data", {24'h0, out_data}, 32'h05);
        drain(20);
        check("single_done", {16'h0, done_count}, 32'd1);
        check("single_occ", {30'h0, occupancy}, 32'd0);
        check("single_busy", {31'h0, busy}, 32'd0);

        // Streaming: one item every STAGE_LAT+1 cycles
        del_q.delete();
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            send(8'(i), 10, w);
            if (i > 0) check("stream_accept_gap", 32'(acc_edge - prev), 32'd3);
            prev = acc_edge;
        end
        drain(60);
        check("stream_count", 32'(del_q.size()), 32'd10);
        for (int i = 1; i < 10; i++)
            if (i < del_q.size()) check("stream_out_gap", 32'(del_q[i] - del_q[i-1]), 32'd3);
        check("stream_done", {16'h0, done_count}, 32'd11);

        // Backpressure fills the chain, then a simultaneous in/out transfer
        out_ready = 1'b0;
        send(8'h10, 40, w);
        send(8'h11, 40, w);
        send(8'h12, 40, w);
        in_valid = 1'b1;
        in_data  = 8'h13;
        repeat (30) @(negedge clk);
        check("bp_in_ready", {31'h0, in_ready}, 32'd0);
        check("bp_occupancy", {30'h0, occupancy}, 32'd3);
        check("bp_out_valid", {31'h0, out_valid}, 32'd1);
        check("bp_out_data", {24'h0, out_data}, 32'h10);
        check("bp_done", {16'h0, done_count}, 32'd11);
        out_ready = 1'b1;
        send(8'h13, 5, w);
        check("bp_same_cycle_accept", 32'(w), 32'd0);
        drain(60);
        check("bp_done_after", {16'h0, done_count}, 32'd15);

        // MODE=1 wrap across three increments
        send(8'hFE, 10, w);
        for (int i = 0; i < 20; i++) begin
            if (out_valid1) break;
            @(negedge clk);
        end
        check("mode1_wrap", {24'h0, out_data1}, 32'h01);
        check("mode0_pass", {24'h0, out_data}, 32'hFE);
        drain(20);
        check("mode_done", {16'h0, done_count}, 32'd16);

        // Flush with two items in flight; offered input must be refused
        send(8'h21, 10, w);
        send(8'h22, 10, w);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        exp_q.delete();
        #1;
        check("flush_in_ready", {31'h0, in_ready}, 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_occ", {30'h0, occupancy}, 32'd0);
        check("flush_out_valid", {31'h0, out_valid}, 32'd0);
        check("flush_busy", {31'h0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        check("flush_done", {16'h0, done_count}, 32'd16);

        // Flush during an attempted delivery: not counted, data kept
        out_ready = 1'b0;
        send(8'h31, 10, w);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        check("flush_dlv_valid", {31'h0, out_valid}, 32'd1);
        out_ready = 1'b1;
        flush     = 1'b1;
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0;
        check("flush_dlv_done", {16'h0, done_count}, 32'd16);
        check("flush_dlv_data", {24'h0, out_data}, 32'h31);
        check("flush_dlv_valid_off", {31'h0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);

        // Asynchronous reset while stage 1 is working
        send(8'h41, 10, w);
        repeat (3) @(negedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        exp_done = 0;
        #1;
        check("arst_out_valid", {31'h0, out_valid}, 32'd0);
        check("arst_out_data", {24'h0, out_data}, 32'd0);
        check("arst_occ", {30'h0, occupancy}, 32'd0);
        check("arst_busy", {31'h0, busy}, 32'd0);
        check("arst_done", {16'h0, done_count}, 32'd0);
        check("arst_in_ready", {31'h0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h42, 10, w);
        check_latency("post_rst");
        check("post_rst_data", {24'h0, out_data}, 32'h42);
        drain(20);
        check("post_rst_done", {16'h0, done_count}, 32'd1);
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/elastic_stage_chain.md
Name: elastic_stage_chain

Overview:
- Synchronous, parametrised successor to the fixed three-stage req/ack processing chain.
- STAGES identical processing stages in series; each stage is busy for STAGE_LAT cycles per item.
- Adjacent stages use valid/ready handshakes with full backpressure, ordered delivery, flush, and occupancy/throughput status.
- Sits between an item producer and a consumer as the design's configurable work pipeline.

Parameters:
DATA_W, 8, item data width in bits (>=1)
STAGES, 3, number of processing stages (>=1)
STAGE_LAT, 2, WORK cycles per item per stage (>=1)
MODE, 0, 0 = pass-through; 1 = each stage adds 1 to data modulo 2^DATA_W

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of all stages
in_valid  input  1  producer has an item
in_ready  output  1  chain accepts an item this cycle
in_data  input  DATA_W  producer item
out_valid  output  1  final stage holds a finished item
out_ready  input  1  consumer accepts the item
out_data  output  DATA_W  finished item
occupancy  output  $clog2(STAGES+1)  number of non-EMPTY stages
done_count  output  16  items delivered (out_valid && out_ready), wraps 0xFFFF->0
busy  output  1  occupancy != 0

Behaviour:
- Per-stage state machine with states EMPTY, WORK, HOLD, plus a counter cnt and a data register.
- Stage k ready_k = (state==EMPTY) || (state==HOLD && take_{k+1}). The upstream of stage 0 is the input port; the downstream of the last stage is out_ready.
- take_k = upstream valid && ready_k, where upstream valid is HOLD of stage k-1, or in_valid for k=0. take_STAGES = out_valid && out_ready.
- On take_k:
  - state <= WORK, cnt <= STAGE_LAT-1.
  - data <= upstream data (MODE=0) or upstream data + 1, truncated to DATA_W (MODE=1).
- WORK: cnt==0 -> HOLD, else cnt <= cnt-1.
- HOLD: hold state and data until take_{k+1}. Then go to EMPTY, or to WORK if take_k occurs in the same cycle.
- Outputs:
  - in_ready = !flush && ready_0.
  - out_valid = (last stage == HOLD).
  - out_data = last-stage data register; it holds its value when out_valid=0.
- Latency: item accepted at edge t0 gives out_valid after edge t0 + STAGES*STAGE_LAT + STAGES - 1 (8 for defaults), when no stall occurs.
- Throughput: one item per STAGE_LAT+1 cycles when out_ready is held high.
- Ordering: strictly FIFO; no item is dropped or duplicated except by flush or reset.
- Backpressure: out_ready=0 freezes the last stage in HOLD. Upstream stages fill and reach HOLD. in_ready falls once all STAGES stages are occupied and stage 0 is in HOLD.
- Flush (synchronous):
  - Priority over every transfer: all stages go to EMPTY next edge.
  - in_ready=0 during the flush cycle; any in_valid in that cycle is not accepted.
  - A delivery attempted in the flush cycle does not count; done_count and data registers are unchanged.
- Reset (async, any time, including mid-WORK):
  - All stages EMPTY, cnt=0, data registers 0, done_count 0.
  - out_valid=0, out_data=0, occupancy=0, busy=0.
  - in_ready=1 while rst is low and flush=0; in_ready=0 while rst is asserted.
- occupancy, busy and done_count are registered and reflect state after each edge. done_count increments on take_STAGES when flush=0.
- Simultaneous in/out: a full chain with out_ready=1 accepts a new item in the same cycle the last stage delivers, if the ready chain propagates to stage 0.

Test Plan:
- Single item, defaults: in_data=0x05 at edge t0, out_ready=1 -> out_valid rises after edge t0+8, out_data=0x05, done_count=1, occupancy back to 0.
- Streaming: 10 back-to-back items 0..9, out_ready=1 -> one acceptance every 3 cycles, outputs 0..9 in order spaced 3 cycles apart, done_count=10.
- Backpressure: out_ready=0, offer 0x10,0x11,0x12,0x13 -> three accepted, occupancy=3, in_ready=0. Raise out_ready -> outputs 0x10,0x11,0x12 then 0x13, in order.
- MODE=1 wrap: DATA_W=8, STAGES=3, in_data=0xFE -> out_data=0x01.
- Flush: with 2 items in flight assert flush one cycle -> next cycle occupancy=0, out_valid=0, done_count unchanged, and no item from before the flush appears later.
- Reset mid-operation: assert rst asynchronously while stage 1 is in WORK -> outputs zero immediately. A new item after release has the full 8-cycle latency and done_count restarts from 0.
